// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the decode-to-X issue controller.
package issue_ctrl_pkg;

    localparam int          REG_IDX_W = 5;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SERIAL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode / X-buffer / writeback / redirect signal bundle of the issue controller.
// master = pipeline environment, slave = issue controller.
interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    logic                 dec_valid_i;
    logic                 dec_ready_o;
    logic [REG_IDX_W-1:0] dec_rs1_i;
    logic [REG_IDX_W-1:0] dec_rs2_i;
    logic                 dec_use_rs1_i;
    logic                 dec_use_rs2_i;
    logic [REG_IDX_W-1:0] dec_rd_i;
    logic                 dec_rd_wen_i;
    logic                 dec_serial_i;
    logic                 x_valid_o;
    logic                 x_ready_i;
    logic                 wb_valid_i;
    logic [REG_IDX_W-1:0] wb_rd_i;
    logic                 wb_rd_wen_i;
    logic                 redir_valid_i;
    logic [31:0]          redir_pc_i;
    logic                 flush_o;
    logic [31:0]          flush_pc_o;
    logic                 busy_o;

    modport master (
        output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i,
               dec_rd_i, dec_rd_wen_i, dec_serial_i, x_ready_i,
               wb_valid_i, wb_rd_i, wb_rd_wen_i, redir_valid_i, redir_pc_i,
        input  dec_ready_o, x_valid_o, flush_o, flush_pc_o, busy_o
    );

    modport slave (
        input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i,
               dec_rd_i, dec_rd_wen_i, dec_serial_i, x_ready_i,
               wb_valid_i, wb_rd_i, wb_rd_wen_i, redir_valid_i, redir_pc_i,
        output dec_ready_o, x_valid_o, flush_o, flush_pc_o, busy_o
    );

endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register plus a
// global in-flight counter, with combinational lookups for hazard checks.
module issue_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int NR_REGS = 32,
    parameter int CNT_W   = 2,
    parameter int INFL_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_en,
    input  logic [REG_IDX_W-1:0] inc_idx,
    input  logic                 dec_en,
    input  logic [REG_IDX_W-1:0] dec_idx,
    input  logic                 infl_inc,
    input  logic                 infl_dec,
    input  logic [REG_IDX_W-1:0] look_rs1,
    input  logic [REG_IDX_W-1:0] look_rs2,
    input  logic [REG_IDX_W-1:0] look_rd,
    output logic [CNT_W-1:0]     cnt_rs1,
    output logic [CNT_W-1:0]     cnt_rs2,
    output logic [CNT_W-1:0]     cnt_rd,
    output logic                 infl_full,
    output logic                 busy,
    output logic                 drained
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NR_REGS-1:0][CNT_W-1:0] cnt;
    logic [NR_REGS-1:0]            up, dn;
    logic [INFL_W-1:0]             infl;
    logic                          reg_underflow;

    // Per-register increment/decrement strobes; x0 never tracked.
    always_comb begin
        up            = '0;
        dn            = '0;
        reg_underflow = 1'b0;
        for (int r = 1; r < NR_REGS; r++) begin
            up[r] = inc_en && (inc_idx == REG_IDX_W'(r));
            dn[r] = dec_en && (dec_idx == REG_IDX_W'(r));
            if (dn[r] && !up[r] && cnt[r] == '0)
                reg_underflow = 1'b1;
        end
    end

    // Register counters: same-cycle inc and dec cancel; saturate at both ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int r = 0; r < NR_REGS; r++) begin
                if (up[r] && !dn[r] && cnt[r] != CNT_MAX)
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dn[r] && !up[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // In-flight counter: issue adds, retirement subtracts, never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n)
            infl <= '0;
        else if (infl_inc && !infl_dec && !infl_full)
            infl <= infl + 1'b1;
        else if (infl_dec && !infl_inc && infl != '0)
            infl <= infl - 1'b1;
    end

    // Retiring more than was issued means the writeback side is broken.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(infl_dec && !infl_inc && infl == '0));
            assert (!reg_underflow);
        end
    end

    assign cnt_rs1   = cnt[look_rs1];
    assign cnt_rs2   = cnt[look_rs2];
    assign cnt_rd    = cnt[look_rd];
    assign infl_full = &infl;
    assign busy      = |infl;
    // Pipeline is empty now or becomes empty at this edge.
    assign drained   = (infl == '0) ||
                       (infl == INFL_W'(1) && infl_dec && !infl_inc);

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: RAW-hazard stall, serialisation of CSR/ecall/mret and
// one-cycle wrong-path flush on redirect.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NR_REGS = 32,
    parameter int CNT_W   = 2,
    parameter int INFL_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    issue_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
    logic             infl_full, busy, drained;
    logic             hazard, go, x_valid, dec_ready, issue;
    logic             sb_inc, sb_dec, redir_take;
    logic             flush_q;
    logic [31:0]      flush_pc_q;

    issue_scoreboard #(
        .NR_REGS (NR_REGS),
        .CNT_W   (CNT_W),
        .INFL_W  (INFL_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_en    (sb_inc),
        .inc_idx   (bus.dec_rd_i),
        .dec_en    (sb_dec),
        .dec_idx   (bus.wb_rd_i),
        .infl_inc  (issue),
        .infl_dec  (bus.wb_valid_i),
        .look_rs1  (bus.dec_rs1_i),
        .look_rs2  (bus.dec_rs2_i),
        .look_rd   (bus.dec_rd_i),
        .cnt_rs1   (cnt_rs1),
        .cnt_rs2   (cnt_rs2),
        .cnt_rd    (cnt_rd),
        .infl_full (infl_full),
        .busy      (busy),
        .drained   (drained)
    );

    // RAW on sources, WAW counter headroom on rd, and global in-flight limit.
    assign hazard = (bus.dec_use_rs1_i && bus.dec_rs1_i != '0 && cnt_rs1 != '0) ||
                    (bus.dec_use_rs2_i && bus.dec_rs2_i != '0 && cnt_rs2 != '0) ||
                    (bus.dec_rd_wen_i  && bus.dec_rd_i  != '0 && cnt_rd == CNT_MAX) ||
                    infl_full;

    assign go = bus.dec_valid_i && !hazard && !bus.redir_valid_i &&
                !(bus.dec_serial_i && busy);

    // Next state and handshake; a redirect always beats issue and serial wait.
    always_comb begin
        state_nxt = state;
        x_valid   = 1'b0;
        dec_ready = 1'b0;
        case (state)
            ST_RUN: begin
                x_valid   = go;
                dec_ready = go && bus.x_ready_i;
                if (bus.redir_valid_i)
                    state_nxt = ST_FLUSH;
                else if (bus.dec_valid_i && bus.dec_serial_i && busy)
                    state_nxt = ST_SERIAL;
            end
            ST_SERIAL: begin
                if (bus.redir_valid_i)
                    state_nxt = ST_FLUSH;
                else if (drained)
                    state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
                dec_ready = 1'b1;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign redir_take = bus.redir_valid_i && state != ST_FLUSH;

    // State, flush pulse and latched redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            flush_q    <= 1'b0;
            flush_pc_q <= RESET_PC;
        end else begin
            state   <= state_nxt;
            flush_q <= (state_nxt == ST_FLUSH);
            if (redir_take)
                flush_pc_q <= bus.redir_pc_i;
        end
    end

    assign bus.x_valid_o   = rst_n && x_valid;
    assign bus.dec_ready_o = rst_n && dec_ready;
    assign bus.flush_o     = flush_q;
    assign bus.flush_pc_o  = flush_pc_q;
    assign bus.busy_o      = busy;

    assign issue  = bus.x_valid_o && bus.x_ready_i;
    assign sb_inc = issue && bus.dec_rd_wen_i && bus.dec_rd_i != '0;
    assign sb_dec = bus.wb_valid_i && bus.wb_rd_wen_i && bus.wb_rd_i != '0;

endmodule
